// File: rtl/line_draw_pkg.sv
// Shared definitions for the Bresenham line-draw controller: default
// coordinate width and the controller state type.
package line_draw_pkg;

    localparam int COORD_W_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/line_step.sv
// One Bresenham step: next pixel and next error term from the current ones.
// Purely combinational; the caller decides when to commit the result.
module line_step
    import line_draw_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic [COORD_W-1:0]        i_cur_x,
    input  logic [COORD_W-1:0]        i_cur_y,
    input  logic signed [COORD_W+1:0] i_err,
    input  logic [COORD_W:0]          i_dx,
    input  logic signed [COORD_W:0]   i_dy,
    input  logic                      i_sx_neg,
    input  logic                      i_sy_neg,
    output logic [COORD_W-1:0]        o_nxt_x,
    output logic [COORD_W-1:0]        o_nxt_y,
    output logic signed [COORD_W+1:0] o_nxt_err
);

    logic signed [COORD_W+2:0] w_e2;
    logic signed [COORD_W+2:0] w_dx_ext;
    logic signed [COORD_W+2:0] w_dy_ext;
    logic signed [COORD_W+2:0] w_err_sum;
    logic                      w_step_x;
    logic                      w_step_y;

    // Everything is widened to the e2 width so both comparisons are signed.
    assign w_e2     = {i_err, 1'b0};
    assign w_dx_ext = {2'b00, i_dx};
    assign w_dy_ext = {{2{i_dy[COORD_W]}}, i_dy};

    // Both axis decisions use the same e2, so a diagonal step applies both.
    always_comb begin
        w_step_x  = (w_e2 >= w_dy_ext);
        w_step_y  = (w_e2 <= w_dx_ext);
        w_err_sum = {i_err[COORD_W+1], i_err};
        o_nxt_x   = i_cur_x;
        o_nxt_y   = i_cur_y;
        if (w_step_x) begin
            w_err_sum = w_err_sum + w_dy_ext;
            o_nxt_x   = i_sx_neg ? (i_cur_x - COORD_W'(1)) : (i_cur_x + COORD_W'(1));
        end else begin
            o_nxt_x   = i_cur_x;
        end
        if (w_step_y) begin
            w_err_sum = w_err_sum + w_dx_ext;
            o_nxt_y   = i_sy_neg ? (i_cur_y - COORD_W'(1)) : (i_cur_y + COORD_W'(1));
        end else begin
            o_nxt_y   = i_cur_y;
        end
        o_nxt_err = w_err_sum[COORD_W+1:0];
    end

endmodule

// File: rtl/line_draw_ctrl.sv
// Line-draw controller: takes a coordinate pair from the AHB slave and streams
// the Bresenham pixels of that line through a valid/ready handshake.
module line_draw_ctrl
    import line_draw_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic               DataValid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               busy,
    output logic               done
);

    state_t                    r_state;
    logic                      r_dv_q;
    logic                      r_pending;
    logic [COORD_W-1:0]        r_cur_x;
    logic [COORD_W-1:0]        r_cur_y;
    logic [COORD_W-1:0]        r_end_x;
    logic [COORD_W-1:0]        r_end_y;
    logic [COORD_W:0]          r_dx;
    logic signed [COORD_W:0]   r_dy;
    logic                      r_sx_neg;
    logic                      r_sy_neg;
    logic signed [COORD_W+1:0] r_err;
    logic                      r_pix_valid;
    logic                      r_pix_last;
    logic                      r_busy;
    logic                      r_done;

    state_t                    w_state_nxt;
    logic                      w_pend_nxt;
    logic                      w_start;
    logic                      w_xfer;
    logic [COORD_W-1:0]        w_adx;
    logic [COORD_W-1:0]        w_ady;
    logic [COORD_W:0]          w_ld_dx;
    logic signed [COORD_W:0]   w_ld_dy;
    logic signed [COORD_W+1:0] w_ld_err;
    logic [COORD_W-1:0]        w_step_x;
    logic [COORD_W-1:0]        w_step_y;
    logic signed [COORD_W+1:0] w_step_err;
    logic [COORD_W-1:0]        w_cur_x_nxt;
    logic [COORD_W-1:0]        w_cur_y_nxt;
    logic [COORD_W-1:0]        w_end_x_nxt;
    logic [COORD_W-1:0]        w_end_y_nxt;
    logic [COORD_W:0]          w_dx_nxt;
    logic signed [COORD_W:0]   w_dy_nxt;
    logic                      w_sx_nxt;
    logic                      w_sy_nxt;
    logic signed [COORD_W+1:0] w_err_nxt;
    logic                      w_last_nxt;

    assign w_start  = DataValid & ~r_dv_q;
    assign w_xfer   = r_pix_valid & pix_ready;

    // Set-up terms taken straight from the live inputs during LOAD.
    assign w_adx    = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
    assign w_ady    = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
    assign w_ld_dx  = {1'b0, w_adx};
    assign w_ld_dy  = -{1'b0, w_ady};
    assign w_ld_err = {1'b0, w_ld_dx} + {w_ld_dy[COORD_W], w_ld_dy};

    line_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .i_cur_x   (r_cur_x),
        .i_cur_y   (r_cur_y),
        .i_err     (r_err),
        .i_dx      (r_dx),
        .i_dy      (r_dy),
        .i_sx_neg  (r_sx_neg),
        .i_sy_neg  (r_sy_neg),
        .o_nxt_x   (w_step_x),
        .o_nxt_y   (w_step_y),
        .o_nxt_err (w_step_err)
    );

    // Next state and pending flag; a start seen in DONE goes straight to LOAD.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pending;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_state_nxt = DRAW;
            end
            DRAW: begin
                if (w_xfer && r_pix_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRAW;
                end
            end
            DONE: begin
                if (r_pending || w_start) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_state_nxt == LOAD) begin
            w_pend_nxt = 1'b0;
        end else if (w_start && (r_state != IDLE)) begin
            w_pend_nxt = 1'b1;
        end else begin
            w_pend_nxt = r_pending;
        end
    end

    // Line set-up in LOAD, one step per accepted pixel in DRAW.
    always_comb begin
        w_cur_x_nxt = r_cur_x;
        w_cur_y_nxt = r_cur_y;
        w_end_x_nxt = r_end_x;
        w_end_y_nxt = r_end_y;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_sx_nxt    = r_sx_neg;
        w_sy_nxt    = r_sy_neg;
        w_err_nxt   = r_err;
        w_last_nxt  = 1'b0;
        case (r_state)
            LOAD: begin
                w_cur_x_nxt = x1;
                w_cur_y_nxt = y1;
                w_end_x_nxt = x2;
                w_end_y_nxt = y2;
                w_dx_nxt    = w_ld_dx;
                w_dy_nxt    = w_ld_dy;
                w_sx_nxt    = (x2 < x1);
                w_sy_nxt    = (y2 < y1);
                w_err_nxt   = w_ld_err;
                w_last_nxt  = (x1 == x2) && (y1 == y2);
            end
            DRAW: begin
                if (w_xfer && !r_pix_last) begin
                    w_cur_x_nxt = w_step_x;
                    w_cur_y_nxt = w_step_y;
                    w_err_nxt   = w_step_err;
                    w_last_nxt  = (w_step_x == r_end_x) && (w_step_y == r_end_y);
                end else if (!w_xfer) begin
                    w_last_nxt  = r_pix_last;
                end else begin
                    w_last_nxt  = 1'b0;
                end
            end
            default: begin
                w_last_nxt = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= IDLE;
            r_dv_q    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dv_q    <= DataValid;
            r_pending <= w_pend_nxt;
        end
    end

    // Line datapath registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_end_x  <= '0;
            r_end_y  <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_err    <= '0;
        end else begin
            r_cur_x  <= w_cur_x_nxt;
            r_cur_y  <= w_cur_y_nxt;
            r_end_x  <= w_end_x_nxt;
            r_end_y  <= w_end_y_nxt;
            r_dx     <= w_dx_nxt;
            r_dy     <= w_dy_nxt;
            r_sx_neg <= w_sx_nxt;
            r_sy_neg <= w_sy_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Status outputs registered from the next state so they are glitch-free.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pix_valid <= (w_state_nxt == DRAW);
            r_pix_last  <= w_last_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    assign pix_x     = r_cur_x;
    assign pix_y     = r_cur_y;
    assign pix_valid = r_pix_valid;
    assign pix_last  = r_pix_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Self-checking bench for line_draw_ctrl: table of known lines, hand-written
// multi-cycle sequences, and random lines checked against an integer model.
module tb_line_draw_ctrl;

    localparam int W = 9;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [W-1:0] x1, y1, x2, y2;
    logic         DataValid;
    logic [W-1:0] pix_x, pix_y;
    logic         pix_valid, pix_ready, pix_last, busy, done;

    line_draw_ctrl #(.COORD_W(W)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .DataValid (DataValid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int x1, y1, x2, y2;
        int mode;   // 0: ready high, 1: ready 1,0,1,0..., 2: random
        int n;
        int off;    // index of first expected (x,y) pair in px_tab
    } vec_t;

    vec_t vecs[7];
    int   px_tab[50];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   got_x[$], got_y[$], got_l[$], exp_x[$], exp_y[$];
    int   done_cyc, last_cyc, first_cyc;
    bit   fin;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int out_code();
        return (((int'(pix_valid) * 2 + int'(pix_last)) * 2 + int'(done)) * 2 + int'(busy)) * 1000000
               + int'(pix_x) * 1000 + int'(pix_y);
    endfunction

    // Reference: Bresenham over plain integers, walking until the end point.
    task automatic model_line(input int ax1, input int ay1, input int ax2, input int ay2);
        int dx, dy, sx, sy, err, e2, x, y;
        exp_x.delete();
        exp_y.delete();
        dx  = (ax2 > ax1) ? ax2 - ax1 : ax1 - ax2;
        dy  = -((ay2 > ay1) ? ay2 - ay1 : ay1 - ay2);
        sx  = (ax2 >= ax1) ? 1 : -1;
        sy  = (ay2 >= ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax1;
        y   = ay1;
        for (int g = 0; g < 2048; g++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == ax2 && y == ay2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Start one line, drain it with the chosen ready pattern, record pixels.
    task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2, input int mode);
        bit pv, pr, pl, rdy;
        int px, py;
        got_x.delete(); got_y.delete(); got_l.delete();
        done_cyc = -1; last_cyc = -1; first_cyc = -1; fin = 1'b0;
        @(negedge HCLK);
        x1 = W'(ax1); y1 = W'(ay1); x2 = W'(ax2); y2 = W'(ay2);
        DataValid = 1'b1;
        pix_ready = 1'b1;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; px = 0; py = 0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge HCLK);
            if (cyc == 0) DataValid = 1'b0;
            if (cyc == 1) begin
                x1 = W'($urandom); y1 = W'($urandom); x2 = W'($urandom); y2 = W'($urandom);
            end
            if (pv && !pr)
                chk(pix_valid && pix_x == px && pix_y == py && pix_last == pl, "hold",
                    out_code(), px * 1000 + py);
            if (done) begin done_cyc = cyc; fin = 1'b1; end
            if (pix_valid && first_cyc < 0) first_cyc = cyc;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 1);
                default: rdy = ($urandom_range(3) != 0);
            endcase
            pix_ready = rdy;
            if (pix_valid && rdy) begin
                got_x.push_back(int'(pix_x));
                got_y.push_back(int'(pix_y));
                got_l.push_back(int'(pix_last));
                last_cyc = cyc;
            end
            pv = pix_valid; pr = rdy; px = int'(pix_x); py = int'(pix_y); pl = pix_last;
        end
        chk(fin, "done_seen", int'(fin), 1);
        chk(first_cyc == 1, "latency", first_cyc, 1);
        chk(done_cyc == last_cyc + 1, "done_timing", done_cyc, last_cyc + 1);
        @(negedge HCLK);
        chk(!done && !busy, "idle_after", out_code(), 0);
    endtask

    task automatic compare_line(input string name);
        int n;
        chk(got_x.size() == exp_x.size(), {name, "_count"}, got_x.size(), exp_x.size());
        n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        for (int i = 0; i < n; i++) begin
            chk(got_x[i] == exp_x[i] && got_y[i] == exp_y[i], $sformatf("%s_pix%0d", name, i),
                got_x[i] * 1000 + got_y[i], exp_x[i] * 1000 + exp_y[i]);
            chk(got_l[i] == int'(i == exp_x.size() - 1), $sformatf("%s_last%0d", name, i),
                got_l[i], int'(i == exp_x.size() - 1));
        end
    endtask

    task automatic expect_cyc(input string name, input bit v, input int ex, input int ey,
                              input bit l, input bit d, input bit b);
        bit ok;
        @(negedge HCLK);
        ok = (pix_valid == v) && (done == d) && (busy == b) &&
             (!v || (int'(pix_x) == ex && int'(pix_y) == ey && pix_last == l));
        chk(ok, name, out_code(),
            (((int'(v) * 2 + int'(l)) * 2 + int'(d)) * 2 + int'(b)) * 1000000 + ex * 1000 + ey);
    endtask

    task automatic expect_zero(input string name);
        chk(!pix_valid && !pix_last && !busy && !done && pix_x == '0 && pix_y == '0,
            name, out_code(), 0);
    endtask

    initial begin
        int cnt;
        vecs = '{'{0, 0, 3, 1, 0, 4, 0},  '{3, 0, 0, 0, 0, 4, 8},   '{0, 3, 0, 0, 0, 4, 16},
                 '{5, 5, 5, 5, 0, 1, 24}, '{0, 0, 4, 4, 1, 5, 26},  '{10, 10, 12, 10, 0, 3, 36},
                 '{2, 5, 5, 3, 2, 4, 42}};
        px_tab = '{0, 0, 1, 0, 2, 1, 3, 1,   3, 0, 2, 0, 1, 0, 0, 0,   0, 3, 0, 2, 0, 1, 0, 0,
                   5, 5,   0, 0, 1, 1, 2, 2, 3, 3, 4, 4,   10, 10, 11, 10, 12, 10,
                   2, 5, 3, 4, 4, 4, 5, 3};

        HRESETn = 1'b0; DataValid = 1'b0; pix_ready = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        repeat (3) @(negedge HCLK);
        expect_zero("reset_state");
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int i = 0; i < 7; i++) begin
            run_line(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].mode);
            exp_x.delete(); exp_y.delete();
            for (int k = 0; k < vecs[i].n; k++) begin
                exp_x.push_back(px_tab[vecs[i].off + 2 * k]);
                exp_y.push_back(px_tab[vecs[i].off + 2 * k + 1]);
            end
            compare_line($sformatf("vec%0d", i));
        end

        // New coordinates while busy, two start events collapsing into one.
        @(negedge HCLK);
        x1 = 9'd0; y1 = 9'd0; x2 = 9'd3; y2 = 9'd1; DataValid = 1'b1; pix_ready = 1'b1;
        expect_cyc("pend_load", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1); DataValid = 1'b0;
        expect_cyc("pend_a0", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
        x1 = 9'd10; y1 = 9'd10; x2 = 9'd12; y2 = 9'd10; DataValid = 1'b1;
        expect_cyc("pend_a1", 1'b1, 1, 0, 1'b0, 1'b0, 1'b1); DataValid = 1'b0;
        expect_cyc("pend_a2", 1'b1, 2, 1, 1'b0, 1'b0, 1'b1); DataValid = 1'b1;
        expect_cyc("pend_a3", 1'b1, 3, 1, 1'b1, 1'b0, 1'b1);
        expect_cyc("pend_done_a", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        expect_cyc("pend_load_b", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        expect_cyc("pend_b0", 1'b1, 10, 10, 1'b0, 1'b0, 1'b1);
        expect_cyc("pend_b1", 1'b1, 11, 10, 1'b0, 1'b0, 1'b1);
        expect_cyc("pend_b2", 1'b1, 12, 10, 1'b1, 1'b0, 1'b1);
        expect_cyc("pend_done_b", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        expect_cyc("pend_idle0", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        expect_cyc("pend_idle1", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        DataValid = 1'b0;

        // Start event landing in the DONE cycle of a one-pixel line.
        @(negedge HCLK);
        x1 = 9'd5; y1 = 9'd5; x2 = 9'd5; y2 = 9'd5; DataValid = 1'b1;
        expect_cyc("dn_load", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1); DataValid = 1'b0;
        expect_cyc("dn_pix", 1'b1, 5, 5, 1'b1, 1'b0, 1'b1);
        expect_cyc("dn_done", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        x1 = 9'd7; y1 = 9'd8; x2 = 9'd7; y2 = 9'd8; DataValid = 1'b1;
        expect_cyc("dn_load2", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        expect_cyc("dn_pix2", 1'b1, 7, 8, 1'b1, 1'b0, 1'b1);
        expect_cyc("dn_done2", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        expect_cyc("dn_idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        DataValid = 1'b0;

        // Reset in the middle of a long diagonal.
        @(negedge HCLK);
        x1 = 9'd0; y1 = 9'd0; x2 = 9'd511; y2 = 9'd511; DataValid = 1'b1; pix_ready = 1'b1;
        @(negedge HCLK);
        DataValid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 100; c++) begin
            @(negedge HCLK);
            if (pix_valid) cnt++;
        end
        chk(cnt == 100 && pix_x == 9'd99 && pix_y == 9'd99, "rst_pre", out_code(), 99099);
        #1 HRESETn = 1'b0;
        #1 expect_zero("rst_immediate");
        repeat (2) @(negedge HCLK);
        expect_zero("rst_hold");
        HRESETn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge HCLK);
            chk(!busy && !done && !pix_valid, "rst_stay_idle", out_code(), 0);
        end
        run_line(1, 1, 3, 2, 0);
        model_line(1, 1, 3, 2);
        compare_line("after_rst");

        for (int i = 0; i < 24; i++) begin
            int a, b, c, d;
            if (i < 12) begin
                a = $urandom_range(15); b = $urandom_range(15);
                c = $urandom_range(15); d = $urandom_range(15);
            end else begin
                a = $urandom_range(511); b = $urandom_range(511);
                c = $urandom_range(511); d = $urandom_range(511);
            end
            model_line(a, b, c, d);
            run_line(a, b, c, d, i % 3);
            compare_line($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
